// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Fairness (forced debug grant) is enabled by defining DMEM_ARB_FAIRNESS_EN.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    S_SHARE = 1'b0,
    S_LOCK  = 1'b1
  } arb_state_e;

  parameter int unsigned DefaultMaxWait = 4;

  // funct3 strobe codes understood by DataMem
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating debug-wait counter; starve flags that the debug port waited MaxWait cycles.
// Only compiled when DMEM_ARB_FAIRNESS_EN is defined.
`ifdef DMEM_ARB_FAIRNESS_EN
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MaxWait = DefaultMaxWait
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic starve
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q == CntMax);

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Arbitrates the MEM-stage DataMem port between the core (default owner) and a debug port.
// DMEM_ARB_FAIRNESS_EN adds a wait counter that forces a debug grant after MAX_WAIT cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DefaultMaxWait
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic        core_stall,
  output logic [31:0] core_rdata,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_funct3,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_strb,
  input  logic [31:0] mem_rdata
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic       starve;
  logic       grant_dbg;
  logic       accept;
  logic       rd_accept;

`ifdef DMEM_ARB_FAIRNESS_EN
  arb_wait_counter #(
    .MaxWait(MAX_WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept | ~dbg_valid),
    .inc   (dbg_valid & ~dbg_ready),
    .starve(starve)
  );
`else
  assign starve = 1'b0;
`endif

  // Nothing is granted or written while reset is held, so a pending access is dropped.
  always_comb begin
    grant_dbg = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_SHARE: grant_dbg = dbg_valid & (~core_req | starve);
        S_LOCK:  grant_dbg = dbg_valid;
      endcase
    end
  end

  assign dbg_ready  = grant_dbg;
  assign accept     = dbg_valid & grant_dbg;
  assign rd_accept  = accept & ~dbg_we;
  assign core_stall = ~rst & core_req & (grant_dbg | (state_q == S_LOCK));
  assign core_rdata = mem_rdata;

  always_comb begin
    if (grant_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_strb  = dbg_funct3;
      mem_we    = dbg_we;
    end else begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_strb  = core_funct3;
      mem_we    = ~rst & core_req & core_we & ~core_stall;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SHARE: if (accept && dbg_lock)  state_d = S_LOCK;
      S_LOCK:  if (accept && !dbg_lock) state_d = S_SHARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SHARE;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      dbg_rvalid <= rd_accept;
      if (rd_accept) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMem and a debug-read scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        dbg_valid, dbg_ready, dbg_we, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [2:0]  dbg_funct3;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_strb;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] mem[0:255];

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_funct3(core_funct3),
    .core_stall (core_stall),
    .core_rdata (core_rdata),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_funct3 (dbg_funct3),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_strb   (mem_strb),
    .mem_rdata  (mem_rdata)
  );

  // DataMem model: combinational read, strobed write at the rising edge
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_strb)
        F3_BYTE: mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        F3_HALF: mem[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[9:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dbg_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("dbg_rdata", dbg_rdata, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_dbg(input logic v, input logic we, input logic lk, input logic [31:0] a,
                         input logic [31:0] d);
    dbg_valid  = v;
    dbg_we     = we;
    dbg_lock   = lk;
    dbg_addr   = a;
    dbg_wdata  = d;
    dbg_funct3 = F3_WORD;
  endtask

  task automatic set_core(input logic r, input logic we, input logic [31:0] a,
                          input logic [31:0] d);
    core_req    = r;
    core_we     = we;
    core_addr   = a;
    core_wdata  = d;
    core_funct3 = F3_WORD;
  endtask

  initial begin
    int waits;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    set_core(1'b1, 1'b1, 32'h40, 32'hBAD0BAD0);
    set_dbg(1'b1, 1'b1, 1'b1, 32'h44, 32'hBAD1BAD1);

    // Reset with both requesters active
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("rst_dbg_ready", {31'd0, dbg_ready}, 32'd0);
      chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
      step();
    end
    rst = 1'b0;
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("rst_state", {31'd0, dut.state_q}, {31'd0, S_SHARE});
    chk("rst_no_write", mem[16], 32'h0);
    step();

    // Core store then load
    set_core(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    sample();
    chk("core_st_stall", {31'd0, core_stall}, 32'd0);
    chk("core_st_we", {31'd0, mem_we}, 32'd1);
    step();
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    sample();
    chk("core_ld_stall", {31'd0, core_stall}, 32'd0);
    chk("core_ld_rdata", core_rdata, 32'hDEADBEEF);
    step();

    // Debug read on an idle core
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    sample();
    chk("dbg_rd_ready", {31'd0, dbg_ready}, 32'd1);
    sb.push_back(32'hDEADBEEF);
    step();
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("dbg_rvalid_hi", {31'd0, dbg_rvalid}, 32'd1);
    step();
    sample();
    chk("dbg_rvalid_lo", {31'd0, dbg_rvalid}, 32'd0);
    step();

    // Starvation: continuous core loads against a debug write
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
    for (int c = 1; c <= (Fair ? 5 : 8); c++) begin
      sample();
      chk($sformatf("starve_ready_c%0d", c), {31'd0, dbg_ready}, {31'd0, Fair && (c == 5)});
      chk($sformatf("starve_stall_c%0d", c), {31'd0, core_stall}, {31'd0, Fair && (c == 5)});
      step();
    end
    if (!Fair) begin
      set_core(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      chk("strict_idle_ready", {31'd0, dbg_ready}, 32'd1);
      step();
      set_core(1'b1, 1'b0, 32'h10, 32'h0);
    end
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("starve_stall_after", {31'd0, core_stall}, 32'd0);
    chk("starve_mem", mem[8], 32'h12345678);
    step();

    // Locked debug burst
    if (!Fair) set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b1, 32'h0, 32'hA0A0A0A0);
    waits = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (dbg_ready) break;
      waits++;
      step();
    end
    chk("lock_wait", waits, Fair ? 32'd4 : 32'd0);
    chk("lock_b1_stall", {31'd0, core_stall}, {31'd0, Fair});
    step();
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    chk("lock_state", {31'd0, dut.state_q}, {31'd0, S_LOCK});
    set_dbg(1'b1, 1'b1, 1'b1, 32'h4, 32'hA1A1A1A1);
    sample();
    chk("lock_b2_ready", {31'd0, dbg_ready}, 32'd1);
    chk("lock_b2_stall", {31'd0, core_stall}, 32'd1);
    step();
    set_dbg(1'b1, 1'b1, 1'b0, 32'h8, 32'hA2A2A2A2);
    sample();
    chk("lock_b3_ready", {31'd0, dbg_ready}, 32'd1);
    chk("lock_b3_stall", {31'd0, core_stall}, 32'd1);
    step();
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("unlock_state", {31'd0, dut.state_q}, {31'd0, S_SHARE});
    chk("unlock_stall", {31'd0, core_stall}, 32'd0);
    chk("lock_mem0", mem[0], 32'hA0A0A0A0);
    chk("lock_mem1", mem[1], 32'hA1A1A1A1);
    chk("lock_mem2", mem[2], 32'hA2A2A2A2);
    step();

    // Reset while locked with a debug write pending
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b1, 32'h30, 32'h55555555);
    sample();
    chk("rl_ready", {31'd0, dbg_ready}, 32'd1);
    step();
    chk("rl_state", {31'd0, dut.state_q}, {31'd0, S_LOCK});
    rst = 1'b1;
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b1, 32'h34, 32'h66666666);
    sample();
    chk("rl_rst_we", {31'd0, mem_we}, 32'd0);
    chk("rl_rst_ready", {31'd0, dbg_ready}, 32'd0);
    chk("rl_rst_stall", {31'd0, core_stall}, 32'd0);
    step();
    rst = 1'b0;
    set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("rl_state_after", {31'd0, dut.state_q}, {31'd0, S_SHARE});
    chk("rl_stall_after", {31'd0, core_stall}, 32'd0);
    chk("rl_mem_kept", mem[12], 32'h55555555);
    chk("rl_mem_dropped", mem[13], 32'h0);
    step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
